// File: rtl/nibble_serial_adder_ctrl_if.sv
// Request/response bundle between a requesting datapath and the nibble-serial adder sequencer.
// NIBBLE_ADDER_SUB_EN adds the sub request bit.
interface nibble_serial_adder_ctrl_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Ci;
`ifdef NIBBLE_ADDER_SUB_EN
  logic             sub;
`endif
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] S;
  logic             Co;

`ifdef NIBBLE_ADDER_SUB_EN
  modport master (output start, A, B, Ci, sub, input  busy, done, S, Co);
  modport slave  (input  start, A, B, Ci, sub, output busy, done, S, Co);
`else
  modport master (output start, A, B, Ci, input  busy, done, S, Co);
  modport slave  (input  start, A, B, Ci, output busy, done, S, Co);
`endif
endinterface

// File: rtl/nibble_serial_adder_ctrl.sv
// WIDTH-bit add sequenced over one shared 4-bit ripple adder, LS nibble first.
// Optional macro NIBBLE_ADDER_SUB_EN enables A-B via the sub request bit.
module nibble_serial_adder_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  nibble_serial_adder_ctrl_if.slave     bus
);
  localparam int NIBBLES = WIDTH / 4;
  localparam int IW      = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_reg, b_reg, s_reg;
  logic [IW-1:0]    idx;
  logic             carry, co_reg, busy_reg, done_reg;
  logic [3:0]       a_nib, b_nib, s_nib;
  logic [4:0]       cy;
  logic             accept;

  assign bus.busy = busy_reg;
  assign bus.done = done_reg;
  assign bus.S    = s_reg;
  assign bus.Co   = co_reg;

  assign accept = bus.start && (state != RUN);

  // The shared adder: four chained full adders on the current nibble.
  always_comb begin
    a_nib = a_reg[{idx, 2'b00} +: 4];
    b_nib = b_reg[{idx, 2'b00} +: 4];
    cy    = '0;
    s_nib = '0;
    cy[0] = carry;
    for (int k = 0; k < 4; k++) begin
      s_nib[k]  = a_nib[k] ^ b_nib[k] ^ cy[k];
      cy[k+1]   = (a_nib[k] & b_nib[k]) | (cy[k] & (a_nib[k] ^ b_nib[k]));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      a_reg    <= '0;
      b_reg    <= '0;
      s_reg    <= '0;
      idx      <= '0;
      carry    <= 1'b0;
      co_reg   <= 1'b0;
      busy_reg <= 1'b0;
      done_reg <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          s_reg[{idx, 2'b00} +: 4] <= s_nib;
          carry                    <= cy[4];
          if (idx == IW'(NIBBLES - 1)) begin
            co_reg   <= cy[4];
            state    <= DONE;
            busy_reg <= 1'b0;
            done_reg <= 1'b1;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        default: begin
          done_reg <= 1'b0;
          state    <= IDLE;
          if (accept) begin
            a_reg    <= bus.A;
            idx      <= '0;
            s_reg    <= '0;
            state    <= RUN;
            busy_reg <= 1'b1;
`ifdef NIBBLE_ADDER_SUB_EN
            // Subtract as A + ~B + 1; B is stored pre-inverted.
            b_reg    <= bus.sub ? ~bus.B : bus.B;
            carry    <= bus.sub ? 1'b1 : bus.Ci;
`else
            b_reg    <= bus.B;
            carry    <= bus.Ci;
`endif
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// Directed self-checking bench for nibble_serial_adder_ctrl at WIDTH=16.
// Sub vectors run only when NIBBLE_ADDER_SUB_EN is defined.
module tb_nibble_serial_adder_ctrl;
  localparam int WIDTH = 16;

  logic clk;
  logic rst_n;
  int   n_cmp = 0;
  int   n_err = 0;

  nibble_serial_adder_ctrl_if #(.WIDTH(WIDTH)) bus ();

  nibble_serial_adder_ctrl #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [15:0] a, input logic [15:0] b, input logic ci);
    bus.A     = a;
    bus.B     = b;
    bus.Ci    = ci;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  // Returns the number of edges until done is seen, or -1 on timeout.
  task automatic wait_done(output int cyc);
    cyc = -1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (bus.done === 1'b1) begin
        cyc = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    n_cmp++;
    if ({bus.busy, bus.done, bus.Co} !== 3'b000 || bus.S !== 16'h0) begin
      n_err++;
      $display("FAIL reset: busy=%b done=%b S=%h Co=%b required all 0", bus.busy, bus.done, bus.S, bus.Co);
    end
  endtask

  task automatic test_basic();
    int cyc;
    do_start(16'h1234, 16'h4321, 1'b0);
    n_cmp++;
    if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin
      n_err++;
      $display("FAIL basic_busy: busy=%b done=%b required busy=1 done=0", bus.busy, bus.done);
    end
    wait_done(cyc);
    n_cmp++;
    if (cyc !== 4) begin
      n_err++;
      $display("FAIL basic_latency: got %0d required 4", cyc);
    end
    n_cmp++;
    if (bus.S !== 16'h5555 || bus.Co !== 1'b0 || bus.busy !== 1'b0) begin
      n_err++;
      $display("FAIL basic_result: S=%h Co=%b busy=%b required 5555 0 0", bus.S, bus.Co, bus.busy);
    end
    tick();
    n_cmp++;
    if (bus.done !== 1'b0 || bus.S !== 16'h5555) begin
      n_err++;
      $display("FAIL basic_hold: done=%b S=%h required 0 5555", bus.done, bus.S);
    end
  endtask

  task automatic test_ripple();
    int cyc;
    do_start(16'hFFFF, 16'h0001, 1'b0);
    wait_done(cyc);
    n_cmp++;
    if (cyc !== 4 || bus.S !== 16'h0000 || bus.Co !== 1'b1) begin
      n_err++;
      $display("FAIL ripple_ffff: cyc=%0d S=%h Co=%b required 4 0000 1", cyc, bus.S, bus.Co);
    end
    tick();
    do_start(16'h0000, 16'h0000, 1'b1);
    wait_done(cyc);
    n_cmp++;
    if (cyc !== 4 || bus.S !== 16'h0001 || bus.Co !== 1'b0) begin
      n_err++;
      $display("FAIL ripple_ci: cyc=%0d S=%h Co=%b required 4 0001 0", cyc, bus.S, bus.Co);
    end
    tick();
  endtask

  task automatic test_start_ignored();
    int dones;
    do_start(16'h00F0, 16'h0010, 1'b0);
    bus.start = 1'b1;
    bus.A     = 16'hAAAA;
    bus.B     = 16'h5555;
    tick();
    tick();
    bus.A     = 16'h0F0F;
    tick();
    bus.start = 1'b0;
    tick();
    n_cmp++;
    if (bus.done !== 1'b1 || bus.S !== 16'h0100 || bus.Co !== 1'b0) begin
      n_err++;
      $display("FAIL ignore_result: done=%b S=%h Co=%b required 1 0100 0", bus.done, bus.S, bus.Co);
    end
    dones = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (bus.done === 1'b1) dones++;
    end
    n_cmp++;
    if (dones !== 0) begin
      n_err++;
      $display("FAIL ignore_extra_done: got %0d extra pulses required 0", dones);
    end
  endtask

  task automatic test_back_to_back();
    int cyc;
    do_start(16'h0011, 16'h0022, 1'b0);
    wait_done(cyc);
    n_cmp++;
    if (cyc !== 4 || bus.S !== 16'h0033) begin
      n_err++;
      $display("FAIL b2b_first: cyc=%0d S=%h required 4 0033", cyc, bus.S);
    end
    do_start(16'h0001, 16'h0002, 1'b0);
    n_cmp++;
    if (bus.busy !== 1'b1 || bus.done !== 1'b0 || bus.S !== 16'h0000) begin
      n_err++;
      $display("FAIL b2b_accept: busy=%b done=%b S=%h required 1 0 0000", bus.busy, bus.done, bus.S);
    end
    wait_done(cyc);
    n_cmp++;
    if (cyc !== 4 || bus.S !== 16'h0003 || bus.Co !== 1'b0) begin
      n_err++;
      $display("FAIL b2b_second: cyc=%0d S=%h Co=%b required 4 0003 0", cyc, bus.S, bus.Co);
    end
    tick();
  endtask

  task automatic test_async_reset();
    int cyc;
    int dones;
    do_start(16'h1234, 16'h4321, 1'b0);
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({bus.busy, bus.done, bus.Co} !== 3'b000 || bus.S !== 16'h0) begin
      n_err++;
      $display("FAIL async_reset: busy=%b done=%b S=%h Co=%b required all 0", bus.busy, bus.done, bus.S, bus.Co);
    end
    tick();
    rst_n = 1'b1;
    dones = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (bus.done === 1'b1 || bus.busy === 1'b1) dones++;
    end
    n_cmp++;
    if (dones !== 0) begin
      n_err++;
      $display("FAIL reset_abandon: got %0d busy/done cycles required 0", dones);
    end
    do_start(16'h1234, 16'h4321, 1'b0);
    wait_done(cyc);
    n_cmp++;
    if (cyc !== 4 || bus.S !== 16'h5555 || bus.Co !== 1'b0) begin
      n_err++;
      $display("FAIL reset_restart: cyc=%0d S=%h Co=%b required 4 5555 0", cyc, bus.S, bus.Co);
    end
    tick();
  endtask

`ifdef NIBBLE_ADDER_SUB_EN
  task automatic test_sub();
    int cyc;
    bus.sub = 1'b1;
    do_start(16'h0005, 16'h0007, 1'b0);
    wait_done(cyc);
    n_cmp++;
    if (cyc !== 4 || bus.S !== 16'hFFFE || bus.Co !== 1'b0) begin
      n_err++;
      $display("FAIL sub_borrow: cyc=%0d S=%h Co=%b required 4 fffe 0", cyc, bus.S, bus.Co);
    end
    tick();
    do_start(16'h0007, 16'h0005, 1'b0);
    wait_done(cyc);
    n_cmp++;
    if (cyc !== 4 || bus.S !== 16'h0002 || bus.Co !== 1'b1) begin
      n_err++;
      $display("FAIL sub_noborrow: cyc=%0d S=%h Co=%b required 4 0002 1", cyc, bus.S, bus.Co);
    end
    bus.sub = 1'b0;
    tick();
  endtask
`endif

  initial begin
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.A     = '0;
    bus.B     = '0;
    bus.Ci    = 1'b0;
`ifdef NIBBLE_ADDER_SUB_EN
    bus.sub   = 1'b0;
`endif
    tick();
    tick();
    test_reset();
    rst_n = 1'b1;
    tick();
    test_basic();
    test_ripple();
    test_start_ignored();
    test_back_to_back();
    test_async_reset();
`ifdef NIBBLE_ADDER_SUB_EN
    test_sub();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
